// File: rtl/fpga_debounce_edge_pkg.sv
// Shared defaults for the debounce/edge-detect block: port width, counter width,
// threshold, prescale ratio and the fixed prescaler width.
package fpga_debounce_edge_pkg;
  localparam int DEF_INPUT_WIDTH     = 8;
  localparam int DEF_CNT_WIDTH       = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_PRESCALE        = 1;
  localparam int PRESCALE_W          = 16;
endpackage

// File: rtl/fpga_debounce_bit.sv
// One debounce lane: stability counter, accepted level and registered rise/fall pulses.
// Advances only on sample ticks; any agreement with the accepted level clears the count.
module fpga_debounce_bit #(
  parameter int CNT_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic din_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 db_q, db_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (din_i == db_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      // Clearing at threshold keeps the counter from ever wrapping.
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        db_d   = din_i;
        rise_d = din_i;
        fall_d = ~din_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/fpga_debounce_edge.sv
// Per-bit debounce filter with edge pulses; shared sample-tick prescaler and
// optional sticky edge status with interrupt, enabled by FPGA_DEBOUNCE_IRQ_EN.
module fpga_debounce_edge
  import fpga_debounce_edge_pkg::*;
#(
  parameter int INPUT_WIDTH     = DEF_INPUT_WIDTH,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PRESCALE        = DEF_PRESCALE
) (
  input  logic                   dest_clk,
  input  logic                   dest_reset,
  input  logic [INPUT_WIDTH-1:0] sync_data,
  input  logic [INPUT_WIDTH-1:0] irq_clear,
  output logic [INPUT_WIDTH-1:0] db_data,
  output logic [INPUT_WIDTH-1:0] rise_pulse,
  output logic [INPUT_WIDTH-1:0] fall_pulse,
  output logic [INPUT_WIDTH-1:0] irq_status,
  output logic                   irq
);
  localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  tick;

  // With PRESCALE=1 the counter sits at zero and tick stays high.
  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge dest_clk or posedge dest_reset) begin
    if (dest_reset) pre_q <= '0;
    else            pre_q <= pre_d;
  end

  genvar i;
  for (i = 0; i < INPUT_WIDTH; i++) begin : g_bit
    fpga_debounce_bit #(
      .CNT_WIDTH      (CNT_WIDTH),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_i (dest_clk),
      .rst_i (dest_reset),
      .tick_i(tick),
      .din_i (sync_data[i]),
      .db_o  (db_data[i]),
      .rise_o(rise_pulse[i]),
      .fall_o(fall_pulse[i])
    );
  end

`ifdef FPGA_DEBOUNCE_IRQ_EN
  logic [INPUT_WIDTH-1:0] status_q, status_d;
  logic                   irq_q;

  // A new edge overrides a clear arriving in the same cycle.
  always_comb begin
    status_d = (status_q & ~irq_clear) | rise_pulse | fall_pulse;
  end

  always_ff @(posedge dest_clk or posedge dest_reset) begin
    if (dest_reset) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= |status_q;
    end
  end

  assign irq_status = status_q;
  assign irq        = irq_q;
`else
  logic unused_irq_clear;
  assign unused_irq_clear = ^irq_clear;
  assign irq_status       = '0;
  assign irq              = 1'b0;
`endif
endmodule

// File: tb/tb_fpga_debounce_edge.sv
// Directed bench for fpga_debounce_edge: four instances with different threshold/prescale
// settings share one stimulus stream; expectations are hand-computed per scenario.
module tb_fpga_debounce_edge;
  localparam int N = 4;
  localparam int DC_TAB [N] = '{1000, 4, 2, 10};
  localparam int PS_TAB [N] = '{1, 1, 3, 1};
`ifdef FPGA_DEBOUNCE_IRQ_EN
  localparam logic [7:0] IRQ_MASK = 8'hFF;
  localparam logic       IRQ_BIT  = 1'b1;
`else
  localparam logic [7:0] IRQ_MASK = 8'h00;
  localparam logic       IRQ_BIT  = 1'b0;
`endif

  logic       dest_clk = 1'b0;
  logic       dest_reset = 1'b1;
  logic [7:0] sync_data = 8'h00;
  logic [7:0] irq_clear = 8'h00;
  logic [7:0] db   [N];
  logic [7:0] rise [N];
  logic [7:0] fall [N];
  logic [7:0] st   [N];
  logic       irq  [N];

  int checks = 0;
  int failures = 0;

  always #5 dest_clk = ~dest_clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    fpga_debounce_edge #(
      .INPUT_WIDTH(8), .CNT_WIDTH(16),
      .DEBOUNCE_CYCLES(DC_TAB[g]), .PRESCALE(PS_TAB[g])
    ) dut (
      .dest_clk  (dest_clk),
      .dest_reset(dest_reset),
      .sync_data (sync_data),
      .irq_clear (irq_clear),
      .db_data   (db[g]),
      .rise_pulse(rise[g]),
      .fall_pulse(fall[g]),
      .irq_status(st[g]),
      .irq       (irq[g])
    );
  end

  task automatic step(input int n);
    repeat (n) @(posedge dest_clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] v);
    sync_data  = v;
    irq_clear  = 8'h00;
    dest_reset = 1'b1;
    step(2);
    dest_reset = 1'b0;
  endtask

  task automatic test_reset;
    step(1);
    sync_data  = 8'hFF;
    dest_reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1);
      for (int d = 0; d < N; d++) begin
        checks++; if (db[d] !== 8'h00) begin failures++; $display("FAIL rst_db dut%0d actual=%h required=00", d, db[d]); end
        checks++; if ((rise[d] | fall[d]) !== 8'h00) begin failures++; $display("FAIL rst_pulse dut%0d actual=%h required=00", d, rise[d] | fall[d]); end
        checks++; if (st[d] !== 8'h00 || irq[d] !== 1'b0) begin failures++; $display("FAIL rst_irq dut%0d actual=%h/%b required=00/0", d, st[d], irq[d]); end
      end
    end
    dest_reset = 1'b0;
    step(999);
    checks++; if (db[0] !== 8'h00) begin failures++; $display("FAIL rst_db_999 actual=%h required=00", db[0]); end
    checks++; if (rise[0] !== 8'h00) begin failures++; $display("FAIL rst_rise_999 actual=%h required=00", rise[0]); end
    step(1);
    checks++; if (db[0] !== 8'hFF) begin failures++; $display("FAIL rst_db_1000 actual=%h required=ff", db[0]); end
    checks++; if (rise[0] !== 8'hFF) begin failures++; $display("FAIL rst_rise_1000 actual=%h required=ff", rise[0]); end
    step(1);
    checks++; if (rise[0] !== 8'h00) begin failures++; $display("FAIL rst_rise_1001 actual=%h required=00", rise[0]); end
  endtask

  task automatic test_glitch;
    do_reset(8'h00);
    sync_data = 8'h01;
    for (int c = 0; c < 3; c++) begin
      step(1);
      checks++; if (db[1] !== 8'h00 || rise[1] !== 8'h00) begin failures++; $display("FAIL glitch_hi%0d actual=%h/%h required=00/00", c, db[1], rise[1]); end
    end
    sync_data = 8'h00;
    for (int c = 0; c < 4; c++) begin
      step(1);
      checks++; if (db[1] !== 8'h00 || rise[1] !== 8'h00) begin failures++; $display("FAIL glitch_lo%0d actual=%h/%h required=00/00", c, db[1], rise[1]); end
    end
    sync_data = 8'h01;
    step(3);
    checks++; if (db[1] !== 8'h00) begin failures++; $display("FAIL accept_early actual=%h required=00", db[1]); end
    step(1);
    checks++; if (db[1] !== 8'h01) begin failures++; $display("FAIL accept_db actual=%h required=01", db[1]); end
    checks++; if (rise[1] !== 8'h01 || fall[1] !== 8'h00) begin failures++; $display("FAIL accept_pulse actual=%h/%h required=01/00", rise[1], fall[1]); end
    step(1);
    checks++; if (rise[1] !== 8'h00 || db[1] !== 8'h01) begin failures++; $display("FAIL accept_after actual=%h/%h required=00/01", rise[1], db[1]); end
  endtask

  task automatic test_prescale;
    do_reset(8'h00);
    sync_data = 8'h08;
    step(5);
    checks++; if (db[2] !== 8'h00) begin failures++; $display("FAIL ps_early actual=%h required=00", db[2]); end
    step(1);
    checks++; if (db[2] !== 8'h08 || rise[2] !== 8'h08) begin failures++; $display("FAIL ps_rise actual=%h/%h required=08/08", db[2], rise[2]); end
    do_reset(8'h00);
    sync_data = 8'h08;
    step(3);
    sync_data = 8'h00;
    step(2);
    sync_data = 8'h08;
    step(1);
    checks++; if (db[2] !== 8'h00) begin failures++; $display("FAIL ps_blip_e6 actual=%h required=00", db[2]); end
    step(2);
    checks++; if (db[2] !== 8'h00) begin failures++; $display("FAIL ps_blip_e8 actual=%h required=00", db[2]); end
    step(1);
    checks++; if (db[2] !== 8'h08 || rise[2] !== 8'h08) begin failures++; $display("FAIL ps_blip_e9 actual=%h/%h required=08/08", db[2], rise[2]); end
  endtask

  task automatic test_fall_indep;
    do_reset(8'h02);
    step(4);
    checks++; if (db[1] !== 8'h02) begin failures++; $display("FAIL indep_pre actual=%h required=02", db[1]); end
    step(1);
    sync_data = 8'h20;
    step(3);
    checks++; if ((rise[1] | fall[1]) !== 8'h00) begin failures++; $display("FAIL indep_early actual=%h required=00", rise[1] | fall[1]); end
    step(1);
    checks++; if (fall[1] !== 8'h02 || rise[1] !== 8'h20) begin failures++; $display("FAIL indep_pulse actual=%h/%h required=02/20", fall[1], rise[1]); end
    checks++; if (db[1] !== 8'h20) begin failures++; $display("FAIL indep_db actual=%h required=20", db[1]); end
    step(1);
    checks++; if ((rise[1] | fall[1]) !== 8'h00) begin failures++; $display("FAIL indep_after actual=%h required=00", rise[1] | fall[1]); end
  endtask

  task automatic test_irq;
    do_reset(8'h00);
    sync_data = 8'h04;
    step(4);
    checks++; if (rise[1] !== 8'h04 || st[1] !== 8'h00) begin failures++; $display("FAIL irq_pulse actual=%h/%h required=04/00", rise[1], st[1]); end
    step(1);
    checks++; if (st[1] !== (8'h04 & IRQ_MASK) || irq[1] !== 1'b0) begin failures++; $display("FAIL irq_set actual=%h/%b required=%h/0", st[1], irq[1], 8'h04 & IRQ_MASK); end
    step(1);
    checks++; if (irq[1] !== IRQ_BIT) begin failures++; $display("FAIL irq_line actual=%b required=%b", irq[1], IRQ_BIT); end
    sync_data = 8'h00;
    step(4);
    checks++; if (fall[1] !== 8'h04) begin failures++; $display("FAIL irq_fall actual=%h required=04", fall[1]); end
    irq_clear = 8'h04;
    step(1);
    irq_clear = 8'h00;
    checks++; if (st[1] !== (8'h04 & IRQ_MASK)) begin failures++; $display("FAIL irq_setwins actual=%h required=%h", st[1], 8'h04 & IRQ_MASK); end
    step(1);
    irq_clear = 8'h04;
    step(1);
    irq_clear = 8'h00;
    checks++; if (st[1] !== 8'h00) begin failures++; $display("FAIL irq_clear actual=%h required=00", st[1]); end
    step(1);
    checks++; if (irq[1] !== 1'b0) begin failures++; $display("FAIL irq_drop actual=%b required=0", irq[1]); end
  endtask

  task automatic test_reset_midcount;
    do_reset(8'h00);
    sync_data = 8'h01;
    step(7);
    checks++; if (db[3] !== 8'h00 || db[1] !== 8'h01) begin failures++; $display("FAIL mid_pre actual=%h/%h required=00/01", db[3], db[1]); end
    #2;
    dest_reset = 1'b1;
    #1;
    checks++; if (db[1] !== 8'h00) begin failures++; $display("FAIL mid_async actual=%h required=00", db[1]); end
    step(2);
    dest_reset = 1'b0;
    step(9);
    checks++; if (db[3] !== 8'h00) begin failures++; $display("FAIL mid_early actual=%h required=00", db[3]); end
    step(1);
    checks++; if (db[3] !== 8'h01 || rise[3] !== 8'h01) begin failures++; $display("FAIL mid_full actual=%h/%h required=01/01", db[3], rise[3]); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_prescale();
    test_fall_indep();
    test_irq();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
